// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - data-memory responder: word RAM below MMIO_BASE, TX FIFO/status/timer page above
// Optional free-running cycle timer enabled by defining DMEM_MMIO_TIMER_EN.
module dmem_mmio_responder #(
   parameter int          RAM_AW    = 12,
   parameter logic [31:0] MMIO_BASE = 32'h0000F000,
   parameter int          FIFO_AW   = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q_dmem,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int RAM_DEPTH  = 1 << RAM_AW;
   localparam int FIFO_DEPTH = 1 << FIFO_AW;

   logic [31:0]        ram [RAM_DEPTH];
   logic [7:0]         fifo_mem [FIFO_DEPTH];

   logic               is_mmio;
   logic [31:0]        offset;
   logic [RAM_AW-1:0]  ram_idx;
   logic               sel_txdata;
   logic               sel_status;
   logic               sel_timer;

   logic [FIFO_AW:0]   wr_ptr;
   logic [FIFO_AW:0]   rd_ptr;
   logic [FIFO_AW:0]   level;
   logic [3:0]         level_sat;
   logic               full;
   logic               empty;
   logic               ovf;
   logic               pop;
   logic               push_req;
   logic               push;
   logic               drop;

   logic [31:0]        timer_rd;
   logic [31:0]        status_word;
   logic [31:0]        rd_mux;

   assign is_mmio    = (address_dmem >= MMIO_BASE);
   assign offset     = address_dmem - MMIO_BASE;
   assign ram_idx    = address_dmem[RAM_AW-1:0];
   assign sel_txdata = is_mmio && (offset == 32'd0);
   assign sel_status = is_mmio && (offset == 32'd1);
   assign sel_timer  = is_mmio && (offset == 32'd2);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign level = wr_ptr - rd_ptr;

   always_comb begin
      level_sat = 4'(level);
      if (32'(level) > 32'd15) begin
         level_sat = 4'hF;
      end
   end

   assign tx_valid = ~empty;
   assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr[FIFO_AW-1:0]];

   assign pop      = tx_valid & tx_ready;
   assign push_req = wren & sel_txdata;
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   assign status_word = {22'b0, ovf, full, empty, 3'b000, level_sat};

`ifdef DMEM_MMIO_TIMER_EN
   logic        sel_tmrclr;
   logic [31:0] timer;
   logic [31:0] timer_nxt;

   assign sel_tmrclr = is_mmio && (offset == 32'd3);
   assign timer_nxt  = (wren && sel_tmrclr) ? 32'd0 : timer + 32'd1;
   // A read returns the count as it stands after this edge's update.
   assign timer_rd   = timer_nxt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer <= 32'd0;
      end else begin
         timer <= timer_nxt;
      end
   end
`else
   assign timer_rd = 32'd0;
`endif

   always_comb begin
      rd_mux = 32'd0;
      if (!is_mmio) begin
         rd_mux = ram[ram_idx];
      end else if (sel_status) begin
         rd_mux = status_word;
      end else if (sel_timer) begin
         rd_mux = timer_rd;
      end
   end

   // RAM contents survive reset; the old word is read before this edge's write lands.
   always_ff @(posedge clock) begin
      if (wren && !is_mmio) begin
         ram[ram_idx] <= data;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr[FIFO_AW-1:0]] <= data[7:0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q_dmem <= 32'd0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         q_dmem <= rd_mux;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // A drop in the same cycle as a STATUS read keeps the flag set.
         if (drop) begin
            ovf <= 1'b1;
         end else if (sel_status) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb/tb_dmem_mmio_responder.sv - self-checking bench for dmem_mmio_responder with a queue-based reference model
module tb_dmem_mmio_responder;

   localparam int          RAM_AW    = 12;
   localparam logic [31:0] MMIO_BASE = 32'h0000F000;
   localparam int          FIFO_AW   = 3;
   localparam int          DEPTH     = 8;
   localparam int          RAM_DEPTH = 4096;
   localparam logic [31:0] A_TX   = MMIO_BASE;
   localparam logic [31:0] A_ST   = MMIO_BASE + 32'd1;
   localparam logic [31:0] A_TM   = MMIO_BASE + 32'd2;
   localparam logic [31:0] A_CLR  = MMIO_BASE + 32'd3;
   localparam logic [31:0] A_IDLE = MMIO_BASE + 32'd4;

   logic        clock;
   logic        reset;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] mdl_ram [int];
   logic [7:0]  mdl_fifo [$];
   logic        mdl_ovf;
   logic [31:0] mdl_timer;

   logic [31:0] exp_q;
   bit          exp_q_known;
   logic        exp_valid;
   logic [7:0]  exp_data;

   dmem_mmio_responder #(
      .RAM_AW   (RAM_AW),
      .MMIO_BASE(MMIO_BASE),
      .FIFO_AW  (FIFO_AW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .address_dmem(address_dmem),
      .data        (data),
      .wren        (wren),
      .q_dmem      (q_dmem),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One clock cycle: drive inputs, advance the model, wait past the edge.
   task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
      int lvl;
      int idx;
      bit do_pop;
      address_dmem = a;
      data         = d;
      wren         = w;
      tx_ready     = r;
      exp_q_known  = 1;
      exp_q        = 32'd0;
      lvl          = mdl_fifo.size();
      if (a < MMIO_BASE) begin
         idx = int'(a % 32'(RAM_DEPTH));
         if (mdl_ram.exists(idx)) exp_q = mdl_ram[idx];
         else exp_q_known = 0;
         if (w) mdl_ram[idx] = d;
      end else begin
         case (a - MMIO_BASE)
            32'd1: exp_q = {22'b0, mdl_ovf, (lvl == DEPTH), (lvl == 0), 3'b000, lvl[3:0]};
`ifdef DMEM_MMIO_TIMER_EN
            32'd2: exp_q = mdl_timer + 32'd1;
`endif
            default: exp_q = 32'd0;
         endcase
      end
      do_pop = (lvl > 0) && r;
      if (do_pop) void'(mdl_fifo.pop_front());
      if (w && a == A_TX) begin
         if (lvl < DEPTH || do_pop) mdl_fifo.push_back(d[7:0]);
         else mdl_ovf = 1'b1;
      end else if (a == A_ST) begin
         mdl_ovf = 1'b0;
      end
      mdl_timer = (w && a == A_CLR) ? 32'd0 : mdl_timer + 32'd1;
      @(posedge clock);
      #1;
      exp_valid = (mdl_fifo.size() > 0);
      exp_data  = (mdl_fifo.size() > 0) ? mdl_fifo[0] : 8'h00;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      address_dmem = A_IDLE; data = 32'd0; wren = 1'b0; tx_ready = 1'b0;
      mdl_fifo.delete(); mdl_ovf = 1'b0; mdl_timer = 32'd0;
      repeat (3) @(posedge clock);
      #1;
      tests_run++;
      if (q_dmem !== 32'd0) begin tests_failed++; $display("FAIL reset_q: got %h expected %h", q_dmem, 32'd0); end
      tests_run++;
      if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", tx_valid); end
      tests_run++;
      if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", tx_data); end
      reset = 1'b1;
      step(A_ST, 32'd0, 1'b0, 1'b0);
      tests_run++;
      if (q_dmem !== 32'h80) begin tests_failed++; $display("FAIL reset_status: got %h expected %h", q_dmem, 32'h80); end
   endtask

   task automatic test_ram();
      step(32'd5, 32'hDEADBEEF, 1'b1, 1'b0);
      step(32'd5, 32'd0, 1'b0, 1'b0);
      tests_run++;
      if (q_dmem !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL ram_rd: got %h expected DEADBEEF", q_dmem); end
      step(32'd5 + 32'(RAM_DEPTH), 32'd0, 1'b0, 1'b0);
      tests_run++;
      if (q_dmem !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL ram_alias: got %h expected DEADBEEF", q_dmem); end
      step(32'd5, 32'hCAFEF00D, 1'b1, 1'b0);
      tests_run++;
      if (q_dmem !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL ram_rbw: got %h expected DEADBEEF", q_dmem); end
      step(32'd5, 32'd0, 1'b0, 1'b0);
      tests_run++;
      if (q_dmem !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL ram_new: got %h expected CAFEF00D", q_dmem); end
   endtask

   task automatic test_push_empty();
      address_dmem = A_TX; data = 32'h77; wren = 1'b1; tx_ready = 1'b1;
      #2;
      tests_run++;
      if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL no_bypass: got %b expected 0", tx_valid); end
      step(A_TX, 32'h77, 1'b1, 1'b1);
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin
         tests_failed++; $display("FAIL push_empty: got %b/%h expected 1/77", tx_valid, tx_data);
      end
      step(A_IDLE, 32'd0, 1'b0, 1'b1);
      tests_run++;
      if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL pop_single: got %b expected 0", tx_valid); end
   endtask

   task automatic test_overflow_drain();
      for (int i = 0; i < 9; i++) step(A_TX, 32'h41 + 32'(i), 1'b1, 1'b0);
      step(A_ST, 32'd0, 1'b0, 1'b0);
      tests_run++;
      if (q_dmem !== 32'h308) begin tests_failed++; $display("FAIL ovf_status: got %h expected 308", q_dmem); end
      step(A_ST, 32'd0, 1'b0, 1'b0);
      tests_run++;
      if (q_dmem !== 32'h108) begin tests_failed++; $display("FAIL ovf_cleared: got %h expected 108", q_dmem); end
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
            tests_failed++; $display("FAIL drain_%0d: got %b/%h expected 1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
         end
         step(A_IDLE, 32'd0, 1'b0, 1'b1);
      end
      tests_run++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
         tests_failed++; $display("FAIL drain_end: got %b/%h expected 0/00", tx_valid, tx_data);
      end
      step(A_ST, 32'd0, 1'b0, 1'b0);
      tests_run++;
      if (q_dmem !== 32'h80) begin tests_failed++; $display("FAIL drain_status: got %h expected 80", q_dmem); end
   endtask

   task automatic test_push_pop_full();
      for (int i = 0; i < 8; i++) step(A_TX, 32'h50 + 32'(i), 1'b1, 1'b0);
      step(A_TX, 32'h60, 1'b1, 1'b1);
      tests_run++;
      if (tx_data !== 8'h51) begin tests_failed++; $display("FAIL full_pushpop_head: got %h expected 51", tx_data); end
      step(A_ST, 32'd0, 1'b0, 1'b0);
      tests_run++;
      if (q_dmem !== 32'h108) begin tests_failed++; $display("FAIL full_pushpop_level: got %h expected 108", q_dmem); end
      for (int i = 0; i < 8; i++) begin
         step(A_IDLE, 32'd0, 1'b0, 1'b1);
         tests_run++;
         if (tx_valid !== exp_valid || tx_data !== exp_data) begin
            tests_failed++; $display("FAIL full_drain_%0d: got %b/%h expected %b/%h", i, tx_valid, tx_data, exp_valid, exp_data);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) step(A_TX, 32'h30 + 32'(i), 1'b1, 1'b0);
      step(32'd5, 32'd0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      mdl_fifo.delete(); mdl_ovf = 1'b0; mdl_timer = 32'd0;
      tests_run++;
      if (tx_valid !== 1'b0 || q_dmem !== 32'd0 || tx_data !== 8'h00) begin
         tests_failed++; $display("FAIL reset_mid: got %b/%h/%h expected 0/00000000/00", tx_valid, q_dmem, tx_data);
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      step(A_ST, 32'd0, 1'b0, 1'b0);
      tests_run++;
      if (q_dmem !== 32'h80) begin tests_failed++; $display("FAIL reset_mid_status: got %h expected 80", q_dmem); end
   endtask

   task automatic test_timer();
      logic [31:0] t1;
      step(A_TM, 32'd0, 1'b0, 1'b0);
      t1 = q_dmem;
      repeat (9) step(A_IDLE, 32'd0, 1'b0, 1'b0);
      step(A_TM, 32'd0, 1'b0, 1'b0);
`ifdef DMEM_MMIO_TIMER_EN
      tests_run++;
      if (q_dmem - t1 !== 32'd10) begin tests_failed++; $display("FAIL timer_delta: got %0d expected 10", q_dmem - t1); end
      step(A_CLR, 32'hFFFF, 1'b1, 1'b0);
      step(A_TM, 32'd0, 1'b0, 1'b0);
      tests_run++;
      if (q_dmem !== 32'd1) begin tests_failed++; $display("FAIL timer_clr: got %h expected 1", q_dmem); end
`else
      tests_run++;
      if (q_dmem !== 32'd0 || t1 !== 32'd0) begin tests_failed++; $display("FAIL timer_off: got %h/%h expected 0/0", t1, q_dmem); end
      step(A_CLR, 32'hFFFF, 1'b1, 1'b0);
      step(A_CLR, 32'd0, 1'b0, 1'b0);
      tests_run++;
      if (q_dmem !== 32'd0) begin tests_failed++; $display("FAIL tmrclr_off: got %h expected 0", q_dmem); end
`endif
   endtask

   task automatic test_random();
      logic [31:0] addrs [4];
      logic [31:0] a;
      int sel;
      addrs[0] = 32'd5; addrs[1] = 32'd9; addrs[2] = 32'd5 + 32'(RAM_DEPTH); addrs[3] = 32'd100;
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 4) a = addrs[sel];
         else if (sel < 7) a = A_TX;
         else a = MMIO_BASE + 32'($urandom_range(1, 5));
         step(a, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
         if (exp_q_known) begin
            tests_run++;
            if (q_dmem !== exp_q) begin tests_failed++; $display("FAIL rand_q_%0d: got %h expected %h", n, q_dmem, exp_q); end
         end
         tests_run++;
         if (tx_valid !== exp_valid || tx_data !== exp_data) begin
            tests_failed++; $display("FAIL rand_tx_%0d: got %b/%h expected %b/%h", n, tx_valid, tx_data, exp_valid, exp_data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_push_empty();
      test_overflow_drain();
      test_push_pop_full();
      test_reset_mid();
      test_timer();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
